mc_ctrl_fsm: RTL
================

Name: mc_ctrl_fsm

Overview:
- Main control state machine of the multicycle processor. It sits directly upstream of the ALU and drives its aluctrl code.
- Sequences fetch, decode, execute, memory and writeback, one micro-step per clk.
- Emits all datapath strobes and mux selects.
- Accounts for the ALU's registered result: alu_result and zero are valid one clk after aluctrl and the operand selects are presented.

Parameters:
- OP_RTYPE, 6'h00, R-type opcode
- OP_LW, 6'h23, load word opcode
- OP_SW, 6'h2B, store word opcode
- OP_BEQ, 6'h04, branch-equal opcode
- OP_J, 6'h02, jump opcode

Ports:
- clk  in  1  single system clock; all state changes on posedge
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  6  IR[31:26]; sampled in DECODE only
- funct  in  6  IR[5:0]; sampled in R_EXEC
- zero  in  1  ALU zero flag; sampled in BEQ_RES only
- aluctrl  out  2  add=00, sub=01, or=10, and=11 (ALU encoding)
- alu_srcA  out  1  0=PC, 1=reg A
- alu_srcB  out  2  00=reg B, 01=const 4, 10=sign-extended imm, 11=sign-extended imm<<2
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load qualified by zero
- pc_source  out  2  00=alu_result, 01=target register, 10=jump address
- target_write  out  1  load target register from alu_result
- iord  out  1  memory address: 0=PC, 1=alu_result
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- ir_write  out  1  IR load
- reg_write  out  1  register file write
- reg_dst  out  1  0=rt, 1=rd
- mem_to_reg  out  1  0=alu_result, 1=memory data
- err  out  1  sticky illegal-instruction flag
- state_o  out  4  current state, for debug

Behaviour:
- Moore machine: outputs are a combinational decode of the state register only. Every output not listed for a state is 0.
- Reset: rst_n=0 forces state S_RST asynchronously. In S_RST all outputs are 0 and err=0. S_RST goes to FETCH on the first posedge after reset release.
- FETCH: mem_read=1, iord=0, ir_write=1, alu_srcA=0, alu_srcB=01, aluctrl=add. Next state: DECODE.
- DECODE: pc_write=1, pc_source=00 (PC+4 is now valid at the ALU output). Decode opcode:
  - R-type: R_EXEC
  - LW or SW: MEM_ADR
  - BEQ: BEQ_TGT
  - J: JUMP
  - any other opcode: ILLEGAL
- R_EXEC: alu_srcA=1, alu_srcB=00, aluctrl from funct: 0x20 add, 0x22 sub, 0x24 and, 0x25 or. Next state: R_WB. Any other funct: ILLEGAL, with no register write.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Next state: FETCH.
- MEM_ADR: alu_srcA=1, alu_srcB=10, aluctrl=add. Next state: MEM_RD for LW, MEM_WR for SW; the opcode decision is held from DECODE.
- MEM_RD: iord=1, mem_read=1. Next state: MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1. Next state: FETCH.
- MEM_WR: iord=1, mem_write=1. Next state: FETCH.
- BEQ_TGT: alu_srcA=0 (PC already holds PC+4), alu_srcB=11, aluctrl=add. Next state: BEQ_CMP.
- BEQ_CMP: target_write=1 (target is valid now), alu_srcA=1, alu_srcB=00, aluctrl=sub. Next state: BEQ_RES.
- BEQ_RES: pc_write_cond=1, pc_source=01. The PC loads only if zero=1. Next state: FETCH.
- JUMP: pc_write=1, pc_source=10. Next state: FETCH.
- ILLEGAL: err=1, all strobes 0. Stays in ILLEGAL until reset.
- Cycles per instruction: J=3; R-type and SW=4; LW and BEQ=5.
- mem_read and mem_write are never both 1 in any state. pc_write and pc_write_cond are never both 1 in any state.
- Reset asserted mid-instruction aborts it immediately; no strobe is asserted after rst_n falls.
- Unused state encodings go to S_RST on the next clk.

Decomposition:
- Package mc_pkg holds:
  - state enum
  - opcode constants and funct constants
  - aluctrl encodings (shared with the ALU)
  - alu_srcB and pc_source select encodings
- Sub-module mc_alu_dec: combinational funct-to-aluctrl decode plus a valid bit. It is instantiated by mc_ctrl_fsm for R_EXEC.

Test Plan:
- Reset and first fetch: hold rst_n=0 for 3 clks with opcode=6'h23 → all outputs 0 and state_o=S_RST; after release, S_RST for 1 clk, then FETCH with mem_read=1, ir_write=1, aluctrl=00, alu_srcB=01.
- R-type or: opcode=0x00, funct=0x25 → state sequence FETCH, DECODE, R_EXEC (aluctrl=10), R_WB (reg_write=1, reg_dst=1), FETCH; 4 clks.
- Load and store: opcode=0x23 → MEM_ADR (aluctrl=00, alu_srcB=10), MEM_RD (iord=1, mem_read=1), MEM_WB (mem_to_reg=1), 5 clks total. opcode=0x2B → 4 clks with mem_write=1 only in MEM_WR.
- BEQ: opcode=0x04 with zero=1 in BEQ_RES → pc_write_cond=1, pc_source=01, target_write=1 one clk earlier, 5 clks. Repeat with zero=0 → same strobes, sequence returns to FETCH.
- Illegal instruction: opcode=0x3F → ILLEGAL after DECODE with err=1 held for 10 clks. Separately, opcode=0x00, funct=0x27 → ILLEGAL with reg_write never asserted. Reset then clears err to 0.
- Reset mid-instruction: drop rst_n during MEM_RD → mem_read falls with no clock edge; restart begins at S_RST, then FETCH.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle control path.
package mc_pkg;

    // Controller states; encodings 14 and 15 are unused and recover to StRst.
    typedef enum logic [3:0] {
        StRst     = 4'd0,
        StFetch   = 4'd1,
        StDecode  = 4'd2,
        StRExec   = 4'd3,
        StRWb     = 4'd4,
        StMemAdr  = 4'd5,
        StMemRd   = 4'd6,
        StMemWb   = 4'd7,
        StMemWr   = 4'd8,
        StBeqTgt  = 4'd9,
        StBeqCmp  = 4'd10,
        StBeqRes  = 4'd11,
        StJump    = 4'd12,
        StIllegal = 4'd13
    } state_e;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    // R-type function codes (IR[5:0])
    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;

    // ALU operation codes, shared with the ALU
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_OR  = 2'b10;
    localparam logic [1:0] ALU_AND = 2'b11;

    // ALU operand B select
    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_TARGET = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_alu_dec.sv
// R-type funct to ALU operation decode, with a flag for supported functs.
module mc_alu_dec
    import mc_pkg::*;
(
    input  logic [5:0] funct_i,
    output logic [1:0] aluctrl_o,
    output logic       valid_o
);

    // Unsupported functs report invalid and fall back to add so the ALU sees a defined code
    always_comb begin
        aluctrl_o = ALU_ADD;
        valid_o   = 1'b1;
        case (funct_i)
            FUNCT_ADD: aluctrl_o = ALU_ADD;
            FUNCT_SUB: aluctrl_o = ALU_SUB;
            FUNCT_AND: aluctrl_o = ALU_AND;
            FUNCT_OR:  aluctrl_o = ALU_OR;
            default:   valid_o   = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Main control state machine of the multicycle processor. Moore outputs are
// decoded from the state register; the ALU result is registered, so each
// state sets up the ALU one step before its result is consumed.
module mc_ctrl_fsm
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic [1:0] aluctrl,
    output logic       alu_srcA,
    output logic [1:0] alu_srcB,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_source,
    output logic       target_write,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       err,
    output logic [3:0] state_o
);

    state_e     state_q, state_d;
    logic       is_lw_q, is_lw_d;
    logic [1:0] r_aluctrl;
    logic       r_valid;

    // zero qualifies the PC load in the datapath through pc_write_cond
    logic unused_zero;
    assign unused_zero = zero;

    mc_alu_dec u_alu_dec (
        .funct_i   (funct),
        .aluctrl_o (r_aluctrl),
        .valid_o   (r_valid)
    );

    // Next-state logic; the load/store choice is captured in DECODE for MEM_ADR
    always_comb begin
        state_d = StRst;
        is_lw_d = is_lw_q;
        unique case (state_q)
            StRst:    state_d = StFetch;
            StFetch:  state_d = StDecode;
            StDecode: begin
                is_lw_d = (opcode == OP_LW);
                case (opcode)
                    OP_RTYPE:     state_d = StRExec;
                    OP_LW, OP_SW: state_d = StMemAdr;
                    OP_BEQ:       state_d = StBeqTgt;
                    OP_J:         state_d = StJump;
                    default:      state_d = StIllegal;
                endcase
            end
            StRExec:   state_d = r_valid ? StRWb : StIllegal;
            StRWb:     state_d = StFetch;
            StMemAdr:  state_d = is_lw_q ? StMemRd : StMemWr;
            StMemRd:   state_d = StMemWb;
            StMemWb:   state_d = StFetch;
            StMemWr:   state_d = StFetch;
            StBeqTgt:  state_d = StBeqCmp;
            StBeqCmp:  state_d = StBeqRes;
            StBeqRes:  state_d = StFetch;
            StJump:    state_d = StFetch;
            StIllegal: state_d = StIllegal;
            default:   state_d = StRst;
        endcase
    end

    // State register with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRst;
            is_lw_q <= 1'b0;
        end else begin
            state_q <= state_d;
            is_lw_q <= is_lw_d;
        end
    end

    // Moore output decode; anything not set for a state stays 0
    always_comb begin
        aluctrl       = ALU_ADD;
        alu_srcA      = 1'b0;
        alu_srcB      = SRCB_REG;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = PCSRC_ALU;
        target_write  = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        err           = 1'b0;
        unique case (state_q)
            StFetch: begin
                mem_read = 1'b1;
                ir_write = 1'b1;
                alu_srcB = SRCB_FOUR;
            end
            StDecode: begin
                // PC+4 computed in FETCH is now at the ALU output
                pc_write  = 1'b1;
                pc_source = PCSRC_ALU;
            end
            StRExec: begin
                alu_srcA = 1'b1;
                alu_srcB = SRCB_REG;
                aluctrl  = r_aluctrl;
            end
            StRWb: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            StMemAdr: begin
                alu_srcA = 1'b1;
                alu_srcB = SRCB_IMM;
            end
            StMemRd: begin
                iord     = 1'b1;
                mem_read = 1'b1;
            end
            StMemWb: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            StMemWr: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            StBeqTgt: begin
                // PC already holds PC+4
                alu_srcB = SRCB_IMM_SH2;
            end
            StBeqCmp: begin
                target_write = 1'b1;
                alu_srcA     = 1'b1;
                alu_srcB     = SRCB_REG;
                aluctrl      = ALU_SUB;
            end
            StBeqRes: begin
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_TARGET;
            end
            StJump: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
            end
            StIllegal: err = 1'b1;
            default: ;
        endcase
    end

    assign state_o = state_q;

endmodule
